// File: rtl/address_gen_pkg.sv
// rtl/address_gen_pkg.sv - shared helpers for the N-dimensional address generator
package address_gen_pkg;

  // Upper bound on loop levels supported by the level priority encoder.
  localparam int MAX_DIMS = 32;

  // Byte-offset shift that turns a word stride into a byte stride.
  function automatic int offset_w(input int data_w);
    if (data_w <= 8) return 0;
    return $clog2(data_w / 8);
  endfunction

  // Index of the lowest clear bit, or MAX_DIMS when every bit is set.
  // Callers pad unused upper bits with ones so they never win.
  function automatic int first_clear(input logic [MAX_DIMS-1:0] v);
    int idx;
    idx = MAX_DIMS;
    for (int i = MAX_DIMS - 1; i >= 0; i--) begin
      if (!v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/address_gen_level.sv
// rtl/address_gen_level.sv - one loop level: trip counter, base register and terminal compare
module address_gen_level #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] base_init_i,
  input  logic              inc_i,
  input  logic              zero_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_load_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [ADDR_W-1:0] base_o,
  output logic              term_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W:0]    cnt_inc;

  // Widened increment so the terminal compare cannot alias on counter wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign term_o  = (cnt_inc == {1'b0, count_i}) || (count_i == '0);
  assign cnt_o   = cnt_q;
  assign base_o  = base_q;

  // Next state: a new run reinitialises, otherwise step/clear/reload as told by the top.
  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    if (clear_i) begin
      cnt_d  = '0;
      base_d = base_init_i;
    end else begin
      if (inc_i)       cnt_d = cnt_inc[CNT_W-1:0];
      else if (zero_i) cnt_d = '0;
      if (load_i)      base_d = base_load_i;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      base_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/address_gen_nd.sv
// rtl/address_gen_nd.sv - N-dimensional address generator with duty, delay and per-level last flags
module address_gen_nd
  import address_gen_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 10,
  parameter int DELAY_W = 7,
  parameter int DATA_W  = 8,
  parameter int DIMS    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   run_i,
  input  logic                   abort_i,
  input  logic [ADDR_W-1:0]      start_i,
  input  logic [CNT_W-1:0]       duty_i,
  input  logic [DIMS*CNT_W-1:0]  count_i,
  input  logic [DIMS*ADDR_W-1:0] stride_i,
  input  logic [DELAY_W-1:0]     delay_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   store_o,
  output logic [DIMS-1:0]        last_o,
  output logic                   done_o
);

  localparam int OFF = offset_w(DATA_W);

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic [DELAY_W-1:0]     delay_q, delay_d;
  logic [CNT_W-1:0]       duty_q, duty_d;
  logic [DIMS*CNT_W-1:0]  count_q, count_d;
  logic [DIMS*ADDR_W-1:0] stride_q, stride_d;

  logic [ADDR_W-1:0] start_sh;
  logic [ADDR_W-1:0] stride_sh [DIMS];
  logic [ADDR_W-1:0] base [DIMS];
  logic [CNT_W-1:0]  cnt [DIMS];
  logic [DIMS-1:0]   term;
  logic [MAX_DIMS-1:0] term_pad;
  logic [DIMS-1:0]   lvl_inc, lvl_zero, lvl_load;
  logic [ADDR_W-1:0] next_base;
  logic              adv, found;
  int                lvl;

  assign start_sh = start_i << OFF;

  for (genvar k = 0; k < DIMS; k++) begin : g_level
    assign stride_sh[k] = stride_q[k*ADDR_W +: ADDR_W] << OFF;

    address_gen_level #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_level (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (run_i),
      .base_init_i (start_sh),
      .inc_i       (lvl_inc[k]),
      .zero_i      (lvl_zero[k]),
      .load_i      (lvl_load[k]),
      .base_load_i (next_base),
      .count_i     (count_q[k*CNT_W +: CNT_W]),
      .cnt_o       (cnt[k]),
      .base_o      (base[k]),
      .term_o      (term[k])
    );

    if (k == 0) begin : g_last0
      assign last_o[k] = term[k];
    end else begin : g_lastk
      assign last_o[k] = last_o[k-1] & term[k];
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign done_o  = done_q;
  assign store_o = cnt[0] < duty_q;

  // A handshake only advances when no run/abort/delay has priority this edge.
  assign adv = valid_q && ready_i && !run_i && !abort_i && (delay_q == '0);

  // Pick the advancing level and derive per-level counter/base controls.
  always_comb begin
    term_pad             = '1;
    term_pad[DIMS-1:0]   = term;
    lvl                  = first_clear(term_pad);
    found                = (lvl < DIMS);
    next_base            = '0;
    lvl_inc              = '0;
    lvl_zero             = '0;
    lvl_load             = '0;
    for (int k = 0; k < DIMS; k++) begin
      if (k == lvl) next_base = base[k] + stride_sh[k];
      lvl_inc[k]  = adv && (k == lvl);
      lvl_zero[k] = adv && found && (k < lvl);
      lvl_load[k] = adv && found && (lvl != 0) && (k <= lvl);
    end
  end

  // Control next state: run > abort > delay countdown > handshake advance.
  always_comb begin
    addr_d   = addr_q;
    valid_d  = valid_q;
    done_d   = done_q;
    delay_d  = delay_q;
    duty_d   = duty_q;
    count_d  = count_q;
    stride_d = stride_q;
    if (run_i) begin
      duty_d   = duty_i;
      count_d  = count_i;
      stride_d = stride_i;
      addr_d   = start_sh;
      done_d   = 1'b0;
      delay_d  = delay_i;
      valid_d  = (delay_i == '0);
    end else if (abort_i) begin
      // Clearing the delay keeps a pending countdown from raising valid later.
      valid_d = 1'b0;
      done_d  = 1'b1;
      delay_d = '0;
    end else if (delay_q != '0) begin
      delay_d = delay_q - DELAY_W'(1);
      valid_d = (delay_q == DELAY_W'(1));
    end else if (adv) begin
      if (lvl == 0) begin
        if (cnt[0] < duty_q) addr_d = addr_q + stride_sh[0];
      end else if (found) begin
        addr_d = next_base;
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // Control and shadow-config registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b1;
      delay_q  <= '0;
      duty_q   <= '0;
      count_q  <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      delay_q  <= delay_d;
      duty_q   <= duty_d;
      count_q  <= count_d;
      stride_q <= stride_d;
    end
  end

endmodule

// File: tb/tb_address_gen_nd.sv
// tb/tb_address_gen_nd.sv - self-checking bench for address_gen_nd
module tb_address_gen_nd;

  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 10;
  localparam int DELAY_W = 7;
  localparam int DATA_W  = 32;
  localparam int DIMS    = 3;
  localparam int SCALE   = DATA_W / 8;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   run_i;
  logic                   abort_i;
  logic [ADDR_W-1:0]      start_i;
  logic [CNT_W-1:0]       duty_i;
  logic [DIMS*CNT_W-1:0]  count_i;
  logic [DIMS*ADDR_W-1:0] stride_i;
  logic [DELAY_W-1:0]     delay_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [ADDR_W-1:0]      addr_o;
  logic                   store_o;
  logic [DIMS-1:0]        last_o;
  logic                   done_o;

  address_gen_nd #(
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .DELAY_W (DELAY_W),
    .DATA_W  (DATA_W),
    .DIMS    (DIMS)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (run_i),
    .abort_i  (abort_i),
    .start_i  (start_i),
    .duty_i   (duty_i),
    .count_i  (count_i),
    .stride_i (stride_i),
    .delay_i  (delay_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .addr_o   (addr_o),
    .store_o  (store_o),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int addr;
    int store;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  int c_start, c_duty, c_delay;
  int c_count [DIMS];
  int c_stride[DIMS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form model: each output position is a mixed-radix index over the loops.
  function automatic void build_model();
    int eff[DIMS];
    int idx[DIMS];
    int total, rem, a, lv, lastv;
    exp_t e;
    exp_q.delete();
    total = 1;
    for (int k = 0; k < DIMS; k++) begin
      eff[k] = (c_count[k] == 0) ? 1 : c_count[k];
      total  = total * eff[k];
    end
    for (int i = 0; i < total; i++) begin
      rem = i;
      for (int k = 0; k < DIMS; k++) begin
        idx[k] = rem % eff[k];
        rem    = rem / eff[k];
      end
      a = c_start;
      for (int k = 1; k < DIMS; k++) a += idx[k] * c_stride[k];
      a += ((idx[0] < c_duty) ? idx[0] : c_duty) * c_stride[0];
      e.addr  = (a * SCALE) & AMASK;
      e.store = (idx[0] < c_duty) ? 1 : 0;
      lv = 1;
      lastv = 0;
      for (int k = 0; k < DIMS; k++) begin
        if (idx[k] != eff[k] - 1) lv = 0;
        lastv |= lv << k;
      end
      e.last = lastv;
      exp_q.push_back(e);
    end
  endfunction

  task automatic start_run();
    @(negedge clk_i);
    start_i = c_start[ADDR_W-1:0];
    duty_i  = c_duty[CNT_W-1:0];
    delay_i = c_delay[DELAY_W-1:0];
    for (int k = 0; k < DIMS; k++) begin
      count_i[k*CNT_W +: CNT_W]    = c_count[k][CNT_W-1:0];
      stride_i[k*ADDR_W +: ADDR_W] = c_stride[k][ADDR_W-1:0];
    end
    run_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
  endtask

  // Start a run from the current config and check every accepted address.
  task automatic run_stream(input bit rnd, input string tag);
    int waited, n, budget;
    build_model();
    ready_i = 1'b0;
    start_run();
    chk({tag, "_busy"}, 32'(done_o), 32'd0);
    waited = 0;
    while (valid_o !== 1'b1 && waited < 300) begin
      @(negedge clk_i);
      waited++;
    end
    chk({tag, "_delay"}, 32'(waited), 32'(c_delay));
    n = 0;
    budget = 0;
    while (n < exp_q.size() && budget < 3000) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_o === 1'b1 && ready_i) begin
        chk({tag, "_addr"},  32'(addr_o),  32'(exp_q[n].addr));
        chk({tag, "_store"}, 32'(store_o), 32'(exp_q[n].store));
        chk({tag, "_last"},  32'(last_o),  32'(exp_q[n].last));
        n++;
      end
      @(negedge clk_i);
      budget++;
    end
    ready_i = 1'b0;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    chk({tag, "_end_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_end_done"},  32'(done_o),  32'd1);
  endtask

  task automatic set_cfg(input int st, input int du, input int dl,
                         input int n0, input int n1, input int n2,
                         input int s0, input int s1, input int s2);
    c_start = st; c_duty = du; c_delay = dl;
    c_count[0] = n0; c_count[1] = n1; c_count[2] = n2;
    c_stride[0] = s0; c_stride[1] = s1; c_stride[2] = s2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; run_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
    start_i = '0; duty_i = '0; count_i = '0; stride_i = '0; delay_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_addr",  32'(addr_o),  32'd0);
    chk("rst_done",  32'(done_o),  32'd1);
    chk("rst_store", 32'(store_o), 32'd0);
    chk("rst_last",  32'(last_o),  32'h7);
    rst_i = 1'b1;

    set_cfg(0, 1023, 0, 4, 3, 0, 1, 16, 0);
    run_stream(1'b0, "seq2d");
    set_cfg(0, 2, 0, 4, 0, 0, 1, 0, 0);
    run_stream(1'b0, "duty");
    set_cfg(5, 1023, 3, 2, 2, 0, 1, 7, 0);
    run_stream(1'b0, "delay3");
    set_cfg(16, 1023, 0, 3, 0, 0, -1, 0, 0);
    run_stream(1'b0, "neg");
    set_cfg(0, 1023, 0, 3, 0, 0, -1, 0, 0);
    run_stream(1'b0, "wrap");
    set_cfg(0, 1023, 0, 4, 3, 0, 1, 16, 0);
    run_stream(1'b1, "rdyrand");
    set_cfg(77, 3, 1, 0, 0, 0, 5, 9, 2);
    run_stream(1'b1, "cnt0");

    set_cfg(0, 1023, 0, 8, 8, 0, 1, 8, 0);
    start_run();
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    ready_i = 1'b0;
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_done",  32'(done_o),  32'd1);
    repeat (3) @(negedge clk_i);
    chk("abort_hold", 32'(valid_o), 32'd0);

    set_cfg(0, 1023, 6, 4, 0, 0, 1, 0, 0);
    start_run();
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("abortdly_valid", 32'(valid_o), 32'd0);
    chk("abortdly_done",  32'(done_o),  32'd1);

    set_cfg(100, 1023, 0, 8, 8, 0, 1, 8, 0);
    start_run();
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    set_cfg(300, 2, 2, 3, 2, 2, -3, 11, -40);
    run_stream(1'b1, "restart");

    set_cfg(200, 1023, 0, 8, 8, 0, 1, 8, 0);
    start_run();
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_addr",  32'(addr_o),  32'd0);
    chk("midrst_done",  32'(done_o),  32'd1);
    rst_i = 1'b1;
    ready_i = 1'b0;

    for (int r = 0; r < 10; r++) begin
      c_start = int'($urandom_range(0, 1023));
      c_duty  = int'($urandom_range(0, 5));
      c_delay = int'($urandom_range(0, 4));
      for (int k = 0; k < DIMS; k++) begin
        c_count[k]  = int'($urandom_range(0, 4));
        c_stride[k] = int'($urandom_range(0, 40)) - 20;
      end
      run_stream(1'b1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
